// File: rtl/tcb_gpio_irq.sv
// GPIO peripheral on a TCB subordinate port with set/clear, edge detect and sticky W1C interrupt status.
// Latency: zero wait states, read data and error are registered one cycle after the transfer.
// Backpressure: none, tcb_rdy is tied high so every valid cycle is a completed transfer.
module tcb_gpio_irq #(
  parameter int unsigned   GW      = 32,
  parameter int unsigned   ADR     = 32,
  parameter int unsigned   CFG_CDC = 2,
  parameter bit            CFG_IRQ = 1'b1,
  parameter logic [GW-1:0] RST_OUT = '0,
  parameter logic [GW-1:0] RST_ENA = '0
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           tcb_vld,
  output logic           tcb_rdy,
  input  logic           tcb_wen,
  input  logic [ADR-1:0] tcb_adr,
  input  logic [3:0]     tcb_byt,
  input  logic [31:0]    tcb_wdt,
  output logic [31:0]    tcb_rdt,
  output logic           tcb_err,
  output logic [GW-1:0]  gpio_o,
  output logic [GW-1:0]  gpio_e,
  input  logic [GW-1:0]  gpio_i,
  output logic           irq
);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_ENA  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_SET  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
  localparam logic [2:0] A_RISE = 3'd5;
  localparam logic [2:0] A_FALL = 3'd6;
  localparam logic [2:0] A_STS  = 3'd7;

  logic [2:0]    sel;
  logic          wr;
  logic [31:0]   bm32;
  logic [31:0]   wd32;
  logic [GW-1:0] bm;
  logic [GW-1:0] wd;
  logic          we_rise, we_fall, we_sts;

  logic [GW-1:0] out_r, ena_r;
  logic [GW-1:0] rise_r, fall_r, sts_r;
  logic          irq_r;
  logic [GW-1:0] gpio_s;
  logic [GW-1:0] rd_gw;
  logic [31:0]   rdt_r;
  logic          err_r;

  // Only word offset bits are decoded; the rest of the address is don't-care.
  logic unused_ok;
  assign unused_ok = ^{tcb_adr, wd32, bm32};

  assign sel  = tcb_adr[4:2];
  assign wr   = tcb_vld & tcb_wen;
  assign bm32 = {{8{tcb_byt[3]}}, {8{tcb_byt[2]}}, {8{tcb_byt[1]}}, {8{tcb_byt[0]}}};
  assign wd32 = tcb_wdt & bm32;
  assign bm   = bm32[GW-1:0];
  assign wd   = wd32[GW-1:0];

  assign we_rise = wr & (sel == A_RISE);
  assign we_fall = wr & (sel == A_FALL);
  assign we_sts  = wr & (sel == A_STS);

  assign tcb_rdy = 1'b1;

  // Input synchroniser chain; depth 0 passes the raw pins straight through.
  generate
    if (CFG_CDC == 0) begin : g_nocdc
      assign gpio_s = gpio_i;
    end else begin : g_cdc
      logic [GW-1:0] sync_r [CFG_CDC];
      // Shift the pins through CFG_CDC flops, cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(CFG_CDC); i++) sync_r[i] <= '0;
        end else begin
          sync_r[0] <= gpio_i;
          for (int i = 1; i < int'(CFG_CDC); i++) sync_r[i] <= sync_r[i-1];
        end
      end
      assign gpio_s = sync_r[CFG_CDC-1];
    end
  endgenerate

  // OUT takes plain byte-masked writes plus atomic set/clear; ENA is a plain register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= RST_OUT;
      ena_r <= RST_ENA;
    end else if (wr) begin
      case (sel)
        A_OUT:   out_r <= (out_r & ~bm) | wd;
        A_SET:   out_r <= out_r | wd;
        A_CLR:   out_r <= out_r & ~wd;
        A_ENA:   ena_r <= (ena_r & ~bm) | wd;
        default: ;
      endcase
    end
  end

  generate
    if (CFG_IRQ) begin : g_irq
      logic [GW-1:0] gpio_p;
      logic [GW-1:0] ev;
      logic [GW-1:0] w1c;

      assign ev  = (gpio_s & ~gpio_p & rise_r) | (~gpio_s & gpio_p & fall_r);
      assign w1c = we_sts ? wd : '0;

      // Edge history, edge enables, sticky status (event beats clear) and registered irq.
      always_ff @(posedge clk) begin
        if (rst) begin
          gpio_p <= '0;
          rise_r <= '0;
          fall_r <= '0;
          sts_r  <= '0;
          irq_r  <= 1'b0;
        end else begin
          gpio_p <= gpio_s;
          if (we_rise) rise_r <= (rise_r & ~bm) | wd;
          if (we_fall) fall_r <= (fall_r & ~bm) | wd;
          sts_r  <= (sts_r & ~w1c) | ev;
          irq_r  <= |sts_r;
        end
      end
    end else begin : g_noirq
      assign rise_r = '0;
      assign fall_r = '0;
      assign sts_r  = '0;
      assign irq_r  = 1'b0;
    end
  endgenerate

  // Read mux over pre-write register state; SET/CLR are write-only and read zero.
  always_comb begin
    rd_gw = '0;
    case (sel)
      A_OUT:   rd_gw = out_r;
      A_ENA:   rd_gw = ena_r;
      A_IN:    rd_gw = gpio_s;
      A_RISE:  rd_gw = rise_r;
      A_FALL:  rd_gw = fall_r;
      A_STS:   rd_gw = sts_r;
      default: rd_gw = '0;
    endcase
  end

  // Response register: updated on every transfer, held otherwise; the map has no error cases.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdt_r <= '0;
      err_r <= 1'b0;
    end else if (tcb_vld) begin
      rdt_r <= 32'(rd_gw);
      err_r <= 1'b0;
    end
  end

  assign tcb_rdt = rdt_r;
  assign tcb_err = err_r;
  assign gpio_o  = out_r;
  assign gpio_e  = ena_r;
  assign irq     = irq_r;

endmodule

// File: tb/tb_tcb_gpio_irq.sv
// Randomised and directed bench for tcb_gpio_irq with a queue-based scoreboard.
// Latency: expected state is pushed before each edge and checked on the following falling edge.
// Backpressure: none, the DUT accepts every cycle.
module tb_tcb_gpio_irq;
  localparam int          GW    = 32;
  localparam int          ADR   = 32;
  localparam int          CDC   = 2;
  localparam bit          IRQ   = 1'b1;
  localparam logic [31:0] R_OUT = 32'hA5A5_0F0F;
  localparam logic [31:0] R_ENA = 32'h0000_FFFF;

  logic           clk = 1'b0;
  logic           rst;
  logic           tcb_vld, tcb_rdy, tcb_wen, tcb_err;
  logic [ADR-1:0] tcb_adr;
  logic [3:0]     tcb_byt;
  logic [31:0]    tcb_wdt, tcb_rdt;
  logic [GW-1:0]  gpio_o, gpio_e, gpio_i;
  logic           irq;

  tcb_gpio_irq #(
    .GW(GW), .ADR(ADR), .CFG_CDC(CDC), .CFG_IRQ(IRQ), .RST_OUT(R_OUT), .RST_ENA(R_ENA)
  ) dut (
    .clk(clk), .rst(rst),
    .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
    .tcb_byt(tcb_byt), .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt), .tcb_err(tcb_err),
    .gpio_o(gpio_o), .gpio_e(gpio_e), .gpio_i(gpio_i), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdt;
    logic [31:0] go;
    logic [31:0] ge;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int   vec = 0;
  int   bad = 0;

  // Reference model state: register contents and the history of sampled pins.
  logic [31:0] m_out, m_ena, m_rise, m_fall, m_sts, m_rdt;
  logic        m_irq;
  logic [31:0] hist[$];  // hist[0] = pins sampled at the most recent edge
  logic [31:0] gi = '0;

  // Apply one cycle of stimulus, advance the model across the coming edge, queue expectations.
  task automatic cyc(input bit r, input bit v, input bit w, input logic [2:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    logic [31:0] s, p, bmk, dm, ev, w1c, rv;
    exp_t e;
    rst     = r;
    tcb_vld = v;
    tcb_wen = w;
    tcb_adr = ($urandom & ~32'h1C) | (32'(a) << 2);
    tcb_byt = b;
    tcb_wdt = d;
    gpio_i  = gi;

    s   = (CDC == 0) ? gi : hist[CDC-1];
    p   = hist[CDC];
    bmk = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    dm  = d & bmk;
    if (r) begin
      m_out = R_OUT; m_ena = R_ENA; m_rise = '0; m_fall = '0; m_sts = '0;
      m_irq = 1'b0;  m_rdt = '0;
      foreach (hist[i]) hist[i] = '0;
    end else begin
      ev  = (s & ~p & m_rise) | (~s & p & m_fall);
      w1c = (v && w && a == 3'd7) ? dm : '0;
      if (v) begin
        case (a)
          3'd0: rv = m_out;
          3'd1: rv = m_ena;
          3'd2: rv = s;
          3'd5: rv = m_rise;
          3'd6: rv = m_fall;
          3'd7: rv = m_sts;
          default: rv = '0;
        endcase
        m_rdt = rv;
        if (w) begin
          case (a)
            3'd0: m_out  = (m_out & ~bmk) | dm;
            3'd1: m_ena  = (m_ena & ~bmk) | dm;
            3'd3: m_out  = m_out | dm;
            3'd4: m_out  = m_out & ~dm;
            3'd5: m_rise = (m_rise & ~bmk) | dm;
            3'd6: m_fall = (m_fall & ~bmk) | dm;
            default: ;
          endcase
        end
      end
      m_irq = (m_sts != 0);
      m_sts = (m_sts & ~w1c) | ev;
      hist.push_front(gi);
      void'(hist.pop_back());
    end
    e.rdt = m_rdt; e.go = m_out; e.ge = m_ena; e.irq = m_irq;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, a, b, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, 4'hF, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'($urandom), 4'hF, $urandom);
  endtask

  // Monitor: pop one expectation per edge and compare every observable output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vec++;
        if (tcb_rdt !== e.rdt) begin
          bad++; $display("FAIL rdt: got %h expected %h at %0t", tcb_rdt, e.rdt, $time);
        end
        vec++;
        if (gpio_o !== e.go) begin
          bad++; $display("FAIL gpio_o: got %h expected %h at %0t", gpio_o, e.go, $time);
        end
        vec++;
        if (gpio_e !== e.ge) begin
          bad++; $display("FAIL gpio_e: got %h expected %h at %0t", gpio_e, e.ge, $time);
        end
        vec++;
        if (irq !== e.irq) begin
          bad++; $display("FAIL irq: got %b expected %b at %0t", irq, e.irq, $time);
        end
        vec++;
        if (tcb_err !== 1'b0 || tcb_rdy !== 1'b1) begin
          bad++; $display("FAIL err_rdy: got err=%b rdy=%b expected err=0 rdy=1 at %0t",
                          tcb_err, tcb_rdy, $time);
        end
      end
    end
  end

  // Driver: directed scenarios followed by randomised traffic.
  initial begin
    for (int i = 0; i <= CDC; i++) hist.push_back('0);
    m_out = R_OUT; m_ena = R_ENA; m_rise = '0; m_fall = '0; m_sts = '0;
    m_irq = 1'b0;  m_rdt = '0;

    gi = 32'h0000_0000;
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'hF, '0);
    cyc(1'b1, 1'b1, 1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) rd(3'(a));

    // Full and byte-lane writes.
    wr(3'd0, 4'hF, 32'h0123_4567);
    wr(3'd1, 4'hF, 32'h7654_3210);
    wr(3'd0, 4'b0010, 32'h0000_AB00);
    rd(3'd0); rd(3'd1);

    // Atomic set / clear; both read zero.
    wr(3'd0, 4'hF, 32'h0000_FFFF);
    wr(3'd3, 4'hF, 32'hF000_0000);
    wr(3'd4, 4'hF, 32'h0000_00FF);
    rd(3'd3); rd(3'd4); rd(3'd0);
    wr(3'd2, 4'hF, 32'hDEAD_BEEF);

    // Synchroniser latency on IN.
    gi = 32'h89AB_CDEF;
    for (int i = 0; i < 4; i++) rd(3'd2);
    gi = 32'hFEDC_BA98;
    for (int i = 0; i < 4; i++) rd(3'd2);

    // Edge detection, sticky status, W1C and irq timing.
    gi = 32'h0; idle(4);
    wr(3'd5, 4'hF, 32'h1);
    wr(3'd6, 4'hF, 32'h2);
    gi = 32'h3; idle(4); rd(3'd7);
    gi = 32'h0; idle(4); rd(3'd7);
    wr(3'd7, 4'hF, 32'h1); rd(3'd7);
    wr(3'd7, 4'hF, 32'h2); idle(2); rd(3'd7);

    // Clear coinciding with a fresh rising event on the same bit.
    gi = 32'h1; idle(4);
    gi = 32'h0; idle(3);
    gi = 32'h1; idle(2);
    wr(3'd7, 4'hF, 32'h1);
    rd(3'd7); idle(1);

    // Reset in the middle of traffic discards the transfer.
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) rd(3'(a));

    // Randomised traffic with pin toggles and occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 2) == 0) gi = gi ^ ($urandom & 32'h0000_00FF);
      if ($urandom_range(0, 7) == 0) gi = $urandom;
      cyc(($urandom_range(0, 149) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          3'($urandom), 4'($urandom), $urandom);
    end

    idle(2);
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
